// File: rtl/hilo_mac_pkg.sv
// Shared op header for the HI/LO multiply/accumulate unit: op codes, FSM states
// and the signed-op classifier.
package hilo_mac_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_mac_unit_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring STEP_BITS multiplier bits per
// run cycle; last is high during the final iteration.
module mac_mul_iter #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic               i_clk,
  input  logic               start,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] partial;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // NOTE: blocking '=' is correct inside always_comb; partial gets a default first so no latch is inferred.
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  // NOTE: pure datapath registers carry no reset; start reloads all of them before use.
  always_ff @(posedge i_clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(N - 1);
    end else if (run) begin
      acc    <= acc + partial;
      mcand  <= mcand << STEP_BITS;
      mplier <= mplier >> STEP_BITS;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign product = acc;
  assign last    = (cnt == '0);

endmodule

// File: rtl/hilo_mac_unit.sv
// HI/LO register pair with iterative MULT/MADD/MSUB (signed and unsigned) and
// MTHI/MTLO; valid/ready issue, one-cycle done pulse, flush abort.
module hilo_mac_unit
  import hilo_mac_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic             i_flush,
  output logic             o_done,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  state_e             state;
  op_e                op_in;
  op_e                op_q;
  logic               neg_q;
  logic               accept;
  logic               start;
  logic               signed_in;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] hilo;
  logic [2*WIDTH-1:0] result;
  logic               last;

  assign op_in     = op_e'(i_op);
  assign o_ready   = (state == ST_IDLE);
  assign o_busy    = ~o_ready;
  assign accept    = i_valid && o_ready && !i_flush;
  assign start     = accept && (op_in != OP_MTHI) && (op_in != OP_MTLO);
  assign signed_in = is_signed_op(op_in);

  // Two's-complement negate of the most-negative value yields itself, which is the correct unsigned magnitude.
  assign rs_mag = (signed_in && i_rs[WIDTH-1]) ? -i_rs : i_rs;
  assign rt_mag = (signed_in && i_rt[WIDTH-1]) ? -i_rt : i_rt;

  mac_mul_iter #(.WIDTH(WIDTH), .STEP_BITS(STEP_BITS)) u_mul (
    .i_clk   (i_clk),
    .start   (start),
    .run     (state == ST_MUL),
    .a       (rs_mag),
    .b       (rt_mag),
    .product (product),
    .last    (last)
  );

  assign hilo   = {o_hi, o_lo};
  assign prod_s = neg_q ? -product : product;

  always_comb begin
    result = hilo;
    case (op_q)
      OP_MULT, OP_MULTU: result = prod_s;
      OP_MADD, OP_MADDU: result = hilo + prod_s;
      OP_MSUB, OP_MSUBU: result = hilo - prod_s;
      default:           result = hilo;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      op_q   <= OP_MULT;
      neg_q  <= 1'b0;
      o_hi   <= '0;
      o_lo   <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op_in)
              OP_MTHI: begin
                o_hi   <= i_rs;
                o_done <= 1'b1;
              end
              OP_MTLO: begin
                o_lo   <= i_rs;
                o_done <= 1'b1;
              end
              default: begin
                op_q  <= op_in;
                neg_q <= signed_in && (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
                state <= ST_MUL;
              end
            endcase
          end
        end
        ST_MUL: begin
          if (i_flush)   state <= ST_IDLE;
          else if (last) state <= ST_ACC;
        end
        ST_ACC: begin
          state <= ST_IDLE;
          // Flush beats the write: an aborted op leaves HI/LO untouched.
          if (!i_flush) begin
            {o_hi, o_lo} <= result;
            o_done       <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Directed bench for hilo_mac_unit: scoreboard of expected HI/LO/latency, checked
// with immediate assertions as each op completes.
module tb_hilo_mac_unit;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] MADD  = 3'd2;
  localparam logic [2:0] MADDU = 3'd3;
  localparam logic [2:0] MSUB  = 3'd4;
  localparam logic [2:0] MSUBU = 3'd5;
  localparam logic [2:0] MTHI  = 3'd6;
  localparam logic [2:0] MTLO  = 3'd7;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, valid4, flush;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        ready, done, busy;
  logic [31:0] hi, lo;
  logic        ready4, done4, busy4;
  logic [31:0] hi4, lo4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_mac_unit #(.WIDTH(32), .STEP_BITS(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_op(op),
    .i_rs(rs), .i_rt(rt), .i_flush(flush), .o_done(done), .o_busy(busy),
    .o_hi(hi), .o_lo(lo)
  );

  hilo_mac_unit #(.WIDTH(32), .STEP_BITS(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid4), .o_ready(ready4), .i_op(op),
    .i_rs(rs), .i_rt(rt), .i_flush(1'b0), .o_done(done4), .o_busy(busy4),
    .o_hi(hi4), .o_lo(lo4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.lat = lat;
    sb.push_back(e);
  endtask

  // Drives one request at the negedge; returns #1 after the acceptance edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid = 1'b1; op = o; rs = a; rt = b;
    check("ready_at_issue", ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    seen = 1'b0;
    lat  = -1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (seen) lat = cyc - acc_cyc;
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_lo"}, lo, e.lo);
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    issue(MTHI, h, 32'h0);
    issue(MTLO, l, 32'h0);
    @(posedge clk);
    #1;
    check("preload_hi", hi, h);
    check("preload_lo", lo, l);
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; valid4 = 1'b0; flush = 1'b0;
    op = MULT; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);

    // 1. MTHI then MTLO back-to-back
    valid = 1'b1; op = MTHI; rs = 32'h12345678;
    @(posedge clk); #1;
    check("mthi_done", done, 1);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", busy, 0);
    @(negedge clk);
    op = MTLO; rs = 32'h9ABCDEF0;
    @(posedge clk); #1;
    check("mtlo_done", done, 1);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", busy, 0);
    valid = 1'b0;
    @(posedge clk); #1;
    check("move_done_pulse_ends", done, 0);

    // 2. MULTU all-ones, STEP_BITS=1 then STEP_BITS=4
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    push_exp(32'hFFFFFFFE, 32'h00000001, 33);
    wait_done("multu_ff");
    check("ready_with_done", ready, 1);

    begin
      int lat4;
      lat4 = -1;
      @(negedge clk);
      valid4 = 1'b1; op = MULTU; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF;
      @(posedge clk); #1;
      acc_cyc = cyc;
      valid4 = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (done4) begin
          lat4 = cyc - acc_cyc;
          break;
        end
        @(posedge clk); #1;
      end
      check("multu_step4_latency", lat4, 9);
      check("multu_step4_hi", hi4, 32'hFFFFFFFE);
      check("multu_step4_lo", lo4, 32'h00000001);
    end

    // 3. Signed multiplies
    issue(MULT, 32'hFFFFFFFF, 32'd5);
    push_exp(32'hFFFFFFFF, 32'hFFFFFFFB, 33);
    wait_done("mult_neg1x5");
    issue(MULT, 32'h80000000, 32'h80000000);
    push_exp(32'h40000000, 32'h00000000, 33);
    wait_done("mult_minxmin");

    // 4. Accumulate with carry/borrow across LO/HI
    set_hilo(32'h0, 32'hFFFFFFFF);
    issue(MADDU, 32'd1, 32'd1);
    push_exp(32'h00000001, 32'h00000000, 33);
    wait_done("maddu_carry");
    set_hilo(32'h0, 32'h0);
    issue(MSUBU, 32'd1, 32'd1);
    push_exp(32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    wait_done("msubu_borrow");
    set_hilo(32'h0, 32'h0);
    issue(MSUB, 32'd2, 32'hFFFFFFFD);
    push_exp(32'h00000000, 32'h00000006, 33);
    wait_done("msub_neg");

    // Back-to-back multiply issue in the done cycle
    issue(MULTU, 32'd7, 32'd6);
    push_exp(32'h0, 32'd42, 33);
    wait_done("b2b_first");
    @(negedge clk);
    check("b2b_ready", ready, 1);

    // 5. Flush during MUL and during ACC
    set_hilo(32'h11, 32'h22);
    issue(MADD, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_mul_ready", ready, 1);
    check("flush_mul_done", done, 0);
    watch_no_done("flush_mul_no_done", 40);
    check("flush_mul_hi", hi, 32'h11);
    check("flush_mul_lo", lo, 32'h22);

    issue(MADD, 32'd3, 32'd4);
    repeat (32) @(posedge clk);
    @(negedge clk);
    check("flush_acc_busy_before", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_acc_ready", ready, 1);
    check("flush_acc_done", done, 0);
    watch_no_done("flush_acc_no_done", 40);
    check("flush_acc_hi", hi, 32'h11);
    check("flush_acc_lo", lo, 32'h22);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; op = MTHI; rs = 32'hCAFE0000;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    check("idle_flush_no_done", done, 0);
    check("idle_flush_hi", hi, 32'h11);

    // 6. Request while busy is ignored
    issue(MULTU, 32'd2, 32'd3);
    push_exp(32'h0, 32'd6, 33);
    @(negedge clk);
    valid = 1'b1; op = MTHI; rs = 32'hDEAD0000;
    repeat (20) @(negedge clk);
    valid = 1'b0;
    wait_done("busy_ignored");
    @(posedge clk); #1;
    check("busy_ignored_hi_after", hi, 32'h0);

    // Reset mid-MUL
    set_hilo(32'hAA, 32'hBB);
    issue(MULT, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_ready", ready, 1);
    watch_no_done("rst_mid_no_done", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
